alu_share_arbiter: RTL and testbench

//  Shares the single RV32 ALU (4-bit alu_control encoding) between two requesters, e.g. a core

---
 rtl/alu_share_arbiter.sv | 81 ++++++++
 tb/tb_alu_share_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one RV32 ALU between two requesters,
// one operation in flight, registered ALU inputs and a held response.
module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [1:0] grant;
    logic       legal;

    // on a tie the requester that did not win last time gets the ALU
    always_comb begin
        grant = (req_valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
        legal = alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    end

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    owner      <= grant[1];
                    last_grant <= grant[1];
                    alu_a      <= grant[1] ? req1_a : req0_a;
                    alu_b      <= grant[1] ? req1_b : req0_b;
                    alu_ctrl   <= grant[1] ? req1_ctrl : req0_ctrl;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_result <= legal ? alu_result : '0;
                    rsp_zero   <= !legal || (alu_result == '0);
                    rsp_err    <= !legal;
                    rsp_valid  <= owner ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: if (rsp_ready[owner]) begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed stimulus against a transaction-level
// arbitration model; responses are checked from a scoreboard queue by a separate monitor.
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_ctrl = '0, req1_ctrl = '0;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = '0;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero, rsp_err;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [3:0]    alu_ctrl;
    logic          busy;

    typedef struct {
        int           owner;
        logic [W-1:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_phase = 0;
    int   m_last = 1;
    int   m_owner = 0;

    alu_share_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // the shared ALU; illegal codes return junk so the arbiter's error path is visible
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl);

    function automatic logic is_legal(input logic [3:0] c);
        return c == 4'd0 || c == 4'd1 || c == 4'd2 || c == 4'd6 || c == 4'd7;
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return 1 - last;
        return v[1] ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level view of the arbiter, advanced once per rising edge
    task automatic model_edge();
        if (m_phase == 0 && req_valid != 2'b00) begin
            exp_t e;
            logic [W-1:0] a, b;
            logic [3:0]   c;
            int g;
            g = pick(req_valid, m_last);
            a = g ? req1_a : req0_a;
            b = g ? req1_b : req0_b;
            c = g ? req1_ctrl : req0_ctrl;
            e.owner = g;
            e.err   = !is_legal(c);
            e.res   = e.err ? '0 : ref_alu(a, b, c);
            e.zero  = e.res == '0;
            sb.push_back(e);
            m_last  = g;
            m_owner = g;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && rsp_ready[m_owner]) begin
            m_phase = 0;
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] c1, input logic [1:0] rr);
        logic [1:0] er;
        @(posedge clk);
        model_edge();
        #1;
        req_valid = v; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_a = a1; req1_b = b1; req1_ctrl = c1; rsp_ready = rr;
        #1;
        er = (m_phase == 0 && v != 2'b00) ? 2'(1 << pick(v, m_last)) : 2'b00;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(m_phase != 0));
    endtask

    task automatic idle(input int n, input logic [1:0] rr);
        for (int i = 0; i < n; i++) step(2'b00, '0, '0, 4'd0, '0, '0, 4'd0, rr);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        sb.delete();
        m_phase = 0;
        m_last = 1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_result", 64'(rsp_result), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // monitor: compares every presented response against the scoreboard head
    initial begin
        int wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid != 2'b00) begin
                    wait_cnt = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    end else begin
                        chk("rsp_valid", 64'(rsp_valid), 64'(1 << sb[0].owner));
                        chk("rsp_result", 64'(rsp_result), 64'(sb[0].res));
                        chk("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
                        chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
                        if (rsp_ready[sb[0].owner]) void'(sb.pop_front());
                    end
                end else if (sb.size() > 0) begin
                    wait_cnt++;
                    if (wait_cnt > 2) begin
                        chk("rsp_timeout", 64'(rsp_valid), 64'(1 << sb[0].owner));
                        void'(sb.pop_front());
                        wait_cnt = 0;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [3:0] legal_tab [5];
        legal_tab = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
        do_reset();
        // single requester add
        step(2'b01, 32'd5, 32'd3, 4'd2, '0, '0, 4'd0, 2'b01);
        idle(4, 2'b01);
        // tie after reset: req0 (7-7) first, then req1 (2|4)
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b11, 32'd7, 32'd7, 4'd6, 32'd2, 32'd4, 4'd1, 2'b11);
        idle(4, 2'b11);
        // sustained contention alternates 0,1,0,1
        for (int i = 0; i < 12; i++) step(2'b11, 32'd9, 32'd4, 4'd6, 32'hFFFF_FFFF, 32'd1, 4'd7, 2'b11);
        idle(4, 2'b11);
        // response held for several cycles of back-pressure
        step(2'b10, '0, '0, 4'd0, 32'hF0F0, 32'h0FF0, 4'd0, 2'b00);
        idle(8, 2'b01);
        idle(3, 2'b10);
        // illegal control code
        step(2'b01, 32'd1, 32'd2, 4'd3, '0, '0, 4'd0, 2'b11);
        idle(4, 2'b11);
        // reset during EXEC drops the op; a fresh request is then served
        step(2'b01, 32'd10, 32'd20, 4'd2, '0, '0, 4'd0, 2'b11);
        step(2'b00, '0, '0, 4'd0, '0, '0, 4'd0, 2'b11);
        do_reset();
        idle(3, 2'b11);
        step(2'b10, '0, '0, 4'd0, 32'd100, 32'd1, 4'd6, 2'b11);
        idle(4, 2'b11);
        // random traffic, including requests withdrawn before grant
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] a0, a1;
            logic [3:0]   c0, c1;
            int r;
            a0 = $urandom;
            a1 = $urandom;
            r  = $urandom_range(0, 5);
            c0 = (r < 5) ? legal_tab[r] : 4'($urandom_range(0, 15));
            r  = $urandom_range(0, 5);
            c1 = (r < 5) ? legal_tab[r] : 4'($urandom_range(0, 15));
            step(2'($urandom_range(0, 3)),
                 a0, ($urandom_range(0, 3) == 0) ? a0 : W'($urandom), c0,
                 a1, ($urandom_range(0, 3) == 0) ? a1 : W'($urandom), c1,
                 2'($urandom_range(0, 3)));
        end
        idle(6, 2'b11);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
